alu_exec_unit: RTL and testbench

Parametrised, handshaked ALU execute stage that replaces the purely combinational ALU-control decode with a registered decode-and-execute unit for the EX stage. It decodes ALUOp/FuncCode, executes single-cycle operations with one-cycle latency, and runs an iterative unsigned multiply into internal HI/LO registers. Results are held in an output register until the downstream stage accepts them.

---
 rtl/alu_exec_if.sv | 34 +++
 rtl/alu_exec_unit.sv | 175 +++++++++++++++++
 tb/tb_alu_exec_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
// alu_exec_if: handshake and data bundle for the ALU execute stage.
//   Request side : in_valid, in_ready, alu_op, func, shamt, op_a, op_b
//   Result side  : out_valid, out_ready, result, zero, illegal
//   Status       : busy (multiply in progress)
// Modports: master drives operations and accepts results; slave is the unit.
interface alu_exec_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_op;
  logic [5:0]       func;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;
  logic             busy;

  modport master (
    output in_valid, alu_op, func, shamt, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal, busy
  );

  modport slave (
    input  in_valid, alu_op, func, shamt, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal, busy
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered decode-and-execute ALU stage.
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active low
//   bus   : alu_exec_if.slave -- operation request (valid/ready), result
//           register (valid/ready) with zero/illegal flags, busy status.
// Single-cycle ops complete one cycle after acceptance. MULTU runs a
// shift-add multiply (one multiplier bit per cycle) into HI/LO; its result
// is LO. The result register holds until the downstream side accepts it.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst_n,
  alu_exec_if.slave bus
);

  localparam int CW = SHW + 1;  // counter must hold the value WIDTH

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_WAIT} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod, prod_step;
  logic [WIDTH:0]   step_sum;

  logic             out_valid_q, zero_q, illegal_q;
  logic [WIDTH-1:0] result_q;

  logic [WIDTH-1:0] exe_res;
  logic             exe_ill, is_mult;
  logic             slot_free, accept, commit, load_single;
  logic             in_ready_c, busy_c;

  // ---------------------------------------------------------------------------
  // Decode and single-cycle execute
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case statements can leave it unassigned (no latches).
  always_comb begin
    exe_res = '0;
    exe_ill = 1'b0;
    is_mult = 1'b0;
    case (bus.alu_op)
      3'b000, 3'b011: exe_res = bus.op_a + bus.op_b;
      3'b001:         exe_res = bus.op_a - bus.op_b;
      3'b100:         exe_res = bus.op_a & bus.op_b;
      3'b101:         exe_res = bus.op_a | bus.op_b;
      default: begin
        case (bus.func)
          6'b100000: exe_res = bus.op_a + bus.op_b;
          6'b100010: exe_res = bus.op_a - bus.op_b;
          6'b100100: exe_res = bus.op_a & bus.op_b;
          6'b100101: exe_res = bus.op_a | bus.op_b;
          6'b100110: exe_res = bus.op_a ^ bus.op_b;
          6'b100111: exe_res = ~(bus.op_a | bus.op_b);
          6'b101010: exe_res = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
          6'b101011: exe_res = {{(WIDTH-1){1'b0}}, (bus.op_a < bus.op_b)};
          6'b000000: exe_res = bus.op_b << bus.shamt;
          6'b000010: exe_res = bus.op_b >> bus.shamt;
          6'b000011: exe_res = $signed(bus.op_b) >>> bus.shamt;
          6'b000100: exe_res = bus.op_b << bus.op_a[SHW-1:0];
          6'b000110: exe_res = bus.op_b >> bus.op_a[SHW-1:0];
          6'b000111: exe_res = $signed(bus.op_b) >>> bus.op_a[SHW-1:0];
          6'b011001: is_mult = 1'b1;
          6'b010000: exe_res = hi_q;
          6'b010010: exe_res = lo_q;
          default:   exe_ill = 1'b1;
        endcase
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  assign slot_free = !out_valid_q || bus.out_ready;

  always_comb begin
    state_nx   = state;
    in_ready_c = 1'b0;
    busy_c     = 1'b1;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        busy_c     = 1'b0;
        in_ready_c = slot_free;
        if (bus.in_valid && slot_free && is_mult) state_nx = S_MUL;
      end
      S_MUL: begin
        if (cnt == CW'(1)) state_nx = S_WAIT;
      end
      S_WAIT: begin
        // Commit HI/LO and the result together once the output slot is free.
        if (slot_free) begin
          commit   = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign accept      = bus.in_valid && in_ready_c;
  assign load_single = accept && !is_mult;

  // Shift-add step: add the multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole product right.
  // The carry out of the add becomes the new top bit.
  assign step_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_step = {step_sum, prod[WIDTH-1:1]};

  // ---------------------------------------------------------------------------
  // Control and architectural state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state <= state_nx;

      if (accept && is_mult)  cnt <= CW'(WIDTH);
      else if (state == S_MUL) cnt <= cnt - 1'b1;

      if (commit) begin
        hi_q <= prod[2*WIDTH-1:WIDTH];
        lo_q <= prod[WIDTH-1:0];
      end

      if (load_single) begin
        out_valid_q <= 1'b1;
        result_q    <= exe_res;
        zero_q      <= (exe_res == '0);
        illegal_q   <= exe_ill;
      end else if (commit) begin
        out_valid_q <= 1'b1;
        result_q    <= prod[WIDTH-1:0];
        zero_q      <= (prod[WIDTH-1:0] == '0);
        illegal_q   <= 1'b0;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // NOTE: the multiply datapath is deliberately left out of reset; it is
  // always reloaded on MULTU acceptance and is never observed before that.
  always_ff @(posedge clk) begin
    if (accept && is_mult) begin
      mcand <= bus.op_a;
      prod  <= {{WIDTH{1'b0}}, bus.op_b};
    end else if (state == S_MUL) begin
      prod <= prod_step;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = busy_c;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed self-checking bench for alu_exec_unit (WIDTH=32).
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// the same point, away from the active edge.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_exec_if #(.WIDTH(W)) bus ();

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.func     = fn;
    bus.shamt    = sh;
    bus.op_a     = a;
    bus.op_b     = b;
  endtask

  typedef struct {
    string       tag;
    logic [2:0]  op;
    logic [5:0]  fn;
    logic [4:0]  sh;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"sll",   3'b010, 6'b000000, 5'd31, 32'h0,        32'h1,        32'h8000_0000};
    vecs[1] = '{"srl",   3'b010, 6'b000010, 5'd31, 32'h0,        32'h8000_0000, 32'h1};
    vecs[2] = '{"sllv",  3'b010, 6'b000100, 5'd0,  32'd4,        32'd3,        32'h30};
    vecs[3] = '{"srlv",  3'b010, 6'b000110, 5'd0,  32'd36,       32'h100,      32'h10};
    vecs[4] = '{"srav",  3'b110, 6'b000111, 5'd0,  32'd1,        32'hFFFF_FFF0, 32'hFFFF_FFF8};
    vecs[5] = '{"xor",   3'b010, 6'b100110, 5'd0,  32'hFF00,     32'h0FF0,     32'hF0F0};
    vecs[6] = '{"nor",   3'b111, 6'b100111, 5'd0,  32'h0,        32'h0,        32'hFFFF_FFFF};
    vecs[7] = '{"add011",3'b011, 6'b111111, 5'd0,  32'd2,        32'd3,        32'd5};
    vecs[8] = '{"sub111",3'b111, 6'b100010, 5'd0,  32'd10,       32'd3,        32'd7};
    vecs[9] = '{"and110",3'b110, 6'b100100, 5'd0,  32'hC,        32'hA,        32'h8};
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_op    = '0;
    bus.func      = '0;
    bus.shamt     = '0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b1;
    step();
    step();

    // Reset state
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result",    bus.result,    0);
    check("rst_flags",     {bus.zero, bus.illegal, bus.busy}, 3'b000);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready",  bus.in_ready,  1);

    // ADD wrap to zero
    drive(3'b000, 6'b0, 5'd0, 32'hFFFF_FFFF, 32'h1);
    step();
    check("add_valid",  bus.out_valid, 1);
    check("add_result", bus.result, 0);
    check("add_flags",  {bus.zero, bus.illegal}, 2'b10);

    // Back-to-back single-cycle ops
    drive(3'b001, 6'b0, 5'd0, 32'd5, 32'd7);
    step();
    check("sub_result", bus.result, 32'hFFFF_FFFE);
    drive(3'b010, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'h1);
    step();
    check("slt_result", bus.result, 32'h1);
    check("slt_ready",  bus.in_ready, 1);
    drive(3'b010, 6'b101011, 5'd0, 32'hFFFF_FFFF, 32'h1);
    step();
    check("sltu_result", bus.result, 32'h0);
    check("sltu_zero",   bus.zero, 1);
    drive(3'b010, 6'b000011, 5'd4, 32'h0, 32'h8000_0000);
    step();
    check("sra_result", bus.result, 32'hF800_0000);
    check("sra_valid",  bus.out_valid, 1);
    bus.in_valid = 1'b0;
    step();
    check("drain_valid", bus.out_valid, 0);

    // Remaining decode table
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].fn, vecs[i].sh, vecs[i].a, vecs[i].b);
      step();
      check(vecs[i].tag, bus.result, vecs[i].exp);
    end
    bus.in_valid = 1'b0;
    step();

    // MULTU 0xFFFFFFFF * 0xFFFFFFFF
    drive(3'b010, 6'b011001, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    #1;
    check("mul_accept_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      check($sformatf("mul_run%0d", k), {bus.busy, bus.in_ready, bus.out_valid}, 3'b100);
      step();
    end
    check("mul_not_early", bus.out_valid, 0);
    step();
    check("mul_valid",  bus.out_valid, 1);
    check("mul_result", bus.result, 32'h1);
    check("mul_idle",   {bus.busy, bus.in_ready}, 2'b01);
    drive(3'b010, 6'b010000, 5'd0, 32'h0, 32'h0);
    step();
    check("mfhi", bus.result, 32'hFFFF_FFFE);
    drive(3'b010, 6'b010010, 5'd0, 32'h0, 32'h0);
    step();
    check("mflo", bus.result, 32'h1);

    // Backpressure
    drive(3'b101, 6'b0, 5'd0, 32'hF0F0, 32'h0F0F);
    step();
    check("or_result", bus.result, 32'hFFFF);
    bus.out_ready = 1'b0;
    drive(3'b100, 6'b0, 5'd0, 32'hFF00, 32'h0FF0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("stall_result%0d", k), bus.result, 32'hFFFF);
      check($sformatf("stall_hs%0d", k), {bus.out_valid, bus.in_ready}, 2'b10);
    end
    bus.out_ready = 1'b1;
    step();
    check("drain_load_valid",  bus.out_valid, 1);
    check("drain_load_result", bus.result, 32'h0F00);
    bus.in_valid = 1'b0;
    step();
    check("after_drain_valid", bus.out_valid, 0);

    // Illegal func
    drive(3'b010, 6'b111111, 5'd0, 32'h1234, 32'h5678);
    step();
    check("ill_result", bus.result, 0);
    check("ill_flags",  {bus.illegal, bus.zero}, 2'b11);
    drive(3'b010, 6'b010000, 5'd0, 32'h0, 32'h0);
    step();
    check("ill_hi_kept", bus.result, 32'hFFFF_FFFE);
    check("ill_cleared", bus.illegal, 0);
    drive(3'b010, 6'b010010, 5'd0, 32'h0, 32'h0);
    step();
    check("ill_lo_kept", bus.result, 32'h1);

    // Reset in the middle of a multiply
    drive(3'b010, 6'b011001, 5'd0, 32'd3, 32'd5);
    step();
    bus.in_valid = 1'b0;
    repeat (10) step();
    check("mid_mul_busy", bus.busy, 1);
    rst_n = 1'b0;
    step();
    check("rst_mul_status", {bus.busy, bus.out_valid}, 2'b00);
    rst_n = 1'b1;
    drive(3'b010, 6'b010010, 5'd0, 32'h0, 32'h0);
    step();
    check("rst_mflo", {bus.out_valid, bus.result}, {1'b1, 32'h0});
    drive(3'b010, 6'b010000, 5'd0, 32'h0, 32'h0);
    step();
    check("rst_mfhi", bus.result, 32'h0);
    bus.in_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
